// File: rtl/vote_tally.sv
// Ballot box: one vote per opened ballot, saturating per-candidate tallies, result display.
// Define VOTE_TALLY_TOTAL_EN to add a saturating total_votes output.
module vote_tally #(
    parameter int unsigned NUM_CAND = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned SEL_W    = $clog2(NUM_CAND)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mode,
    input  logic                      ballot_open,
    input  logic [NUM_CAND-1:0]       vote_valid,
    input  logic [SEL_W-1:0]          result_sel,
    output logic                      ballot_ready,
    output logic                      vote_ack,
    output logic                      vote_err,
    output logic                      sat,
    output logic [SEL_W-1:0]          candidate_id,
    output logic [CNT_W-1:0]          vote_count
`ifdef VOTE_TALLY_TOTAL_EN
    ,
    output logic [CNT_W+SEL_W-1:0]    total_votes
`endif
);

    typedef enum logic [1:0] {StIdle, StArmed, StCommit, StResult} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      tally_q [NUM_CAND];
    logic [CNT_W-1:0]      tally_d [NUM_CAND];
    logic [SEL_W-1:0]      idx_q, idx_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  sat_q, sat_d;
    logic [SEL_W-1:0]      cand_q, cand_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  any_vote;
    logic                  multi_vote;
    logic                  single_vote;
    logic [SEL_W-1:0]      vote_idx;
    logic [CNT_W-1:0]      sel_count;

    // Clearing the lowest set bit leaves something behind only if two or more bits were set.
    assign any_vote    = |vote_valid;
    assign multi_vote  = |(vote_valid & (vote_valid - NUM_CAND'(1)));
    assign single_vote = any_vote && !multi_vote;

    always_comb begin
        vote_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_valid[i]) begin
                vote_idx = SEL_W'(i);
            end
        end
    end

    // Out-of-range selections match no entry and display zero.
    always_comb begin
        sel_count = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (result_sel == SEL_W'(i)) begin
                sel_count = tally_q[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mode) begin
                    state_d = StResult;
                end else if (ballot_open) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (mode) begin
                    state_d = StResult;
                end else if (single_vote) begin
                    state_d = StCommit;
                end
            end
            StCommit: state_d = StIdle;
            StResult: begin
                if (!mode) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ballot_ready = (state_q == StArmed);
        ack_d        = (state_q == StCommit);
        err_d        = (state_q == StArmed) && !mode && multi_vote;
        sat_d        = sat_q;
        cand_d       = cand_q;
        count_d      = '0;
        idx_d        = idx_q;
        tally_d      = tally_q;

        if ((state_q == StArmed) && !mode && single_vote) begin
            idx_d = vote_idx;
        end

        if (state_q == StCommit) begin
            cand_d = idx_q;
            if (tally_q[idx_q] == CntMax) begin
                sat_d = 1'b1;
            end else begin
                tally_d[idx_q] = tally_q[idx_q] + CNT_W'(1);
            end
        end

        // Loading on entry as well gives a valid display one cycle after mode rises.
        if (state_d == StResult) begin
            cand_d  = result_sel;
            count_d = sel_count;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
            cand_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM_CAND; i++) begin
                tally_q[i] <= '0;
            end
        end else begin
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
            cand_q  <= cand_d;
            count_q <= count_d;
            tally_q <= tally_d;
        end
    end

    assign vote_ack     = ack_q;
    assign vote_err     = err_q;
    assign sat          = sat_q;
    assign candidate_id = cand_q;
    assign vote_count   = count_q;

`ifdef VOTE_TALLY_TOTAL_EN
    logic [CNT_W+SEL_W-1:0] total_q;

    // Counts every commit, including those to an already saturated candidate.
    always_ff @(posedge clock) begin
        if (reset) begin
            total_q <= '0;
        end else if ((state_q == StCommit) && (total_q != '1)) begin
            total_q <= total_q + (CNT_W + SEL_W)'(1);
        end
    end

    assign total_votes = total_q;
`endif

endmodule

// File: tb/tb_vote_tally.sv
// Randomized bench for vote_tally, checked against an array-based tally model.
module tb_vote_tally;

    localparam int NC  = 4;
    localparam int CW  = 8;
    localparam int SW  = 2;
    localparam int MAX = 255;

    logic          clock       = 1'b0;
    logic          reset       = 1'b1;
    logic          mode        = 1'b0;
    logic          ballot_open = 1'b0;
    logic [NC-1:0] vote_valid  = '0;
    logic [SW-1:0] result_sel  = '0;
    logic          ballot_ready;
    logic          vote_ack;
    logic          vote_err;
    logic          sat;
    logic [SW-1:0] candidate_id;
    logic [CW-1:0] vote_count;
`ifdef VOTE_TALLY_TOTAL_EN
    logic [CW+SW-1:0] total_votes;
    int               model_total;
`endif

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int model[NC];
    bit model_sat;

    vote_tally #(
        .NUM_CAND (NC),
        .CNT_W    (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mode         (mode),
        .ballot_open  (ballot_open),
        .vote_valid   (vote_valid),
        .result_sel   (result_sel),
        .ballot_ready (ballot_ready),
        .vote_ack     (vote_ack),
        .vote_err     (vote_err),
        .sat          (sat),
        .candidate_id (candidate_id),
        .vote_count   (vote_count)
`ifdef VOTE_TALLY_TOTAL_EN
        ,
        .total_votes  (total_votes)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) model[i] = 0;
        model_sat = 1'b0;
`ifdef VOTE_TALLY_TOTAL_EN
        model_total = 0;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1; mode = 1'b0; ballot_open = 1'b0; vote_valid = '0;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic open_ballot();
        ballot_open = 1'b1;
        tick();
        ballot_open = 1'b0;
        check("open_ready", ballot_ready, 1);
        check("open_no_ack", vote_ack, 0);
    endtask

    // Casts a single vote in an open ballot; returns in the acknowledge cycle.
    task automatic do_vote(input int c);
        vote_valid = '0;
        vote_valid[c] = 1'b1;
        tick();
        vote_valid = '0;
        check("commit_ready_low", ballot_ready, 0);
        check("commit_ack_early", vote_ack, 0);
        tick();
        if (model[c] >= MAX) model_sat = 1'b1;
        else model[c] = model[c] + 1;
        check("vote_ack", vote_ack, 1);
        check("vote_cand", candidate_id, c);
        check("vote_sat", sat, model_sat);
`ifdef VOTE_TALLY_TOTAL_EN
        if (model_total < 1023) model_total = model_total + 1;
        check("total_votes", total_votes, model_total);
`endif
    endtask

    task automatic multi_err(input logic [NC-1:0] vec);
        vote_valid = vec;
        tick();
        vote_valid = '0;
        check("err_pulse", vote_err, 1);
        check("err_ready", ballot_ready, 1);
        check("err_no_ack", vote_ack, 0);
        tick();
        check("err_clear", vote_err, 0);
        check("err_ready2", ballot_ready, 1);
    endtask

    task automatic read_result(input int sel);
        int sel2;
        mode = 1'b1;
        result_sel = SW'(sel);
        tick();
        check("res_count", vote_count, model[sel]);
        check("res_cand", candidate_id, sel);
        check("res_ready", ballot_ready, 0);
        sel2 = $urandom_range(NC - 1, 0);
        result_sel = SW'(sel2);
        tick();
        check("res_count2", vote_count, model[sel2]);
        check("res_cand2", candidate_id, sel2);
        mode = 1'b0;
        tick();
        check("res_exit_count", vote_count, 0);
    endtask

    initial begin
        int c;
        logic [NC-1:0] vec;

        do_reset();
        repeat (5) tick();
        check("rst_ready", ballot_ready, 0);
        check("rst_ack", vote_ack, 0);
        check("rst_err", vote_err, 0);
        check("rst_sat", sat, 0);
        check("rst_cand", candidate_id, 0);
        check("rst_count", vote_count, 0);

        // Stray vote while idle is ignored.
        vote_valid = 4'b0010;
        tick();
        vote_valid = '0;
        check("idle_vote_ack", vote_ack, 0);
        check("idle_vote_err", vote_err, 0);
        tick();
        check("idle_vote_ack2", vote_ack, 0);
        read_result(1);

        open_ballot();
        tick();
        check("armed_wait", ballot_ready, 1);
        do_vote(2);
        tick();
        read_result(2);

        open_ballot();
        multi_err(4'b0011);
        do_vote(0);
        tick();
        read_result(0);
        read_result(1);
        read_result(3);

        // Open and vote in the same idle cycle: ballot opens, vote dropped.
        ballot_open = 1'b1;
        vote_valid = 4'b0010;
        tick();
        ballot_open = 1'b0;
        vote_valid = '0;
        check("same_open_ready", ballot_ready, 1);
        tick();
        check("same_open_ready2", ballot_ready, 1);
        check("same_open_ack", vote_ack, 0);
        do_vote(3);
        tick();

        // Mode beats a vote in the same armed cycle.
        open_ballot();
        mode = 1'b1;
        vote_valid = 4'b1000;
        result_sel = 2'd3;
        tick();
        vote_valid = '0;
        check("modewin_ready", ballot_ready, 0);
        check("modewin_ack", vote_ack, 0);
        check("modewin_count", vote_count, model[3]);
        check("modewin_cand", candidate_id, 3);
        tick();
        check("modewin_ack2", vote_ack, 0);
        check("modewin_count2", vote_count, model[3]);
        mode = 1'b0;
        tick();
        check("modewin_exit", vote_count, 0);

        for (int n = 0; n < 40; n++) begin
            open_ballot();
            if ($urandom_range(3, 0) == 0) begin
                do vec = NC'($urandom_range(15, 0)); while ($countones(vec) < 2);
                multi_err(vec);
            end
            repeat ($urandom_range(2, 0)) begin
                tick();
                check("rand_wait_ready", ballot_ready, 1);
            end
            c = $urandom_range(NC - 1, 0);
            do_vote(c);
            if ($urandom_range(1, 0) == 1) tick();
            if ((n % 8) == 7) read_result($urandom_range(NC - 1, 0));
        end
        for (int i = 0; i < NC; i++) read_result(i);

        // Saturation of candidate 3 from a clean start.
        do_reset();
        for (int n = 0; n < 257; n++) begin
            open_ballot();
            do_vote(3);
        end
        tick();
        check("sat_flag", sat, 1);
        read_result(3);
        read_result(0);

        // Reset while a ballot is open discards everything.
        do_reset();
        open_ballot(); do_vote(0);
        open_ballot(); do_vote(1);
        open_ballot(); do_vote(2);
        open_ballot();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        check("midrst_ready", ballot_ready, 0);
        check("midrst_sat", sat, 0);
        check("midrst_ack", vote_ack, 0);
        tick();
        check("midrst_ready2", ballot_ready, 0);
        for (int i = 0; i < NC; i++) read_result(i);
        open_ballot();
        do_vote(1);
        tick();
        read_result(1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vote_tally.md
# vote_tally

- Ballot-box stage directly downstream of the per-button debounce/valid-vote generators.
- Accepts one debounced single-cycle vote pulse per candidate line and enforces one vote per ballot, opened by the officer's ballot-open pulse.
- Keeps a saturating per-candidate tally.
- Presents a selected candidate's tally in result mode.

## Interface

- NUM_CAND, 4, number of candidate vote lines (2..16)
- CNT_W, 8, width of each per-candidate tally
- SEL_W, derived = $clog2(NUM_CAND), candidate index width
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; reset reset, synchronous, active-high; clock clock
- mode  in  1  0 = voting, 1 = result display
- ballot_open  in  1  single-cycle pulse from officer's debounced button
- vote_valid  in  NUM_CAND  single-cycle debounced vote pulses, bit i = candidate i
- result_sel  in  SEL_W  candidate index to display in result mode
- ballot_ready  out  1  high while a ballot is open (voter may press)
- vote_ack  out  1  one-cycle pulse: vote committed
- vote_err  out  1  one-cycle pulse: more than one vote_valid bit seen while armed
- sat  out  1  sticky: some tally has saturated
- candidate_id  out  SEL_W  last committed index (voting) / displayed index (result)
- vote_count  out  CNT_W  tally of candidate_id in result mode, 0 otherwise

## Operation

- FSM states: IDLE, ARMED, COMMIT, RESULT. All registered.
- IDLE:
  - mode=1 -> RESULT.
  - ballot_open=1 (mode=0) -> ARMED.
  - vote_valid ignored, not counted, no vote_err.
- ARMED:
  - mode=1 -> RESULT; the open ballot is discarded, no count.
  - Exactly one vote_valid bit set -> latch its index, go to COMMIT.
  - Two or more bits set -> vote_err pulse next cycle, stay ARMED, nothing counted.
  - ballot_open ignored.
- COMMIT:
  - tally[idx] += 1, saturating at 2^CNT_W-1.
  - An increment attempted at max leaves tally unchanged and sets sat.
  - candidate_id <= idx.
  - Next state IDLE.
  - vote_valid ignored.
- RESULT:
  - candidate_id <= result_sel; vote_count <= tally[result_sel], every cycle.
  - mode=0 -> IDLE; vote_count <= 0.
  - result_sel >= NUM_CAND displays vote_count 0.
- Tallies persist across mode changes; only reset clears them.
- Reset values: state IDLE, all tallies 0, ballot_ready 0, vote_ack 0, vote_err 0, sat 0, candidate_id 0, vote_count 0.
- Reset mid-ballot or mid-COMMIT: the pending vote is lost and all tallies clear.

## Timing

- ballot_open at cycle N -> ballot_ready high from N+1.
- Valid single vote at cycle M (ARMED):
  - state COMMIT at M+1; ballot_ready low from M+1.
  - Tally updated and vote_ack high at M+2 (one cycle); state IDLE at M+2.
- Earliest next ballot_open is accepted at M+2.
- vote_err: high exactly at M+1 for a multi-bit vote at M; ballot_ready stays high.
- Result mode:
  - result_sel change at cycle R -> vote_count/candidate_id valid at R+1.
  - Entering RESULT at cycle S -> first valid display at S+1.
- ballot_open and vote_valid in the same IDLE cycle: the ballot opens and the vote is ignored.
- mode=1 and a vote in the same ARMED cycle: mode wins and the vote is discarded.

## Configuration

- VOTE_TALLY_TOTAL_EN defined:
  - Adds output total_votes, width CNT_W+SEL_W, reset 0.
  - Increments by 1 in the COMMIT cycle for every commit, including commits to a saturated candidate.
  - Saturates at all-ones.
  - Readable in any mode.
- Undefined: port and logic absent; all other behaviour identical.

## Test plan

- Reset, then idle 5 cycles -> all outputs 0; vote_valid=4'b0010 pulse in IDLE -> no vote_ack, RESULT shows tally[1]=0.
- ballot_open, then vote_valid=4'b0100 two cycles later -> vote_ack exactly 2 cycles after the vote; mode=1, result_sel=2 -> vote_count=1 one cycle later, candidate_id=2.
- ARMED with vote_valid=4'b0011 -> vote_err one cycle, ballot_ready stays 1; then 4'b0001 -> candidate 0 tally=1, candidates 1 and 3 =0.
- 257 ballots for candidate 3 (CNT_W=8) -> vote_count=255, sat=1 after the 256th commit; with VOTE_TALLY_TOTAL_EN, total_votes=257.
- ballot_open, then mode=1 in the same cycle as vote_valid=4'b1000 -> no vote_ack, tally[3] unchanged, state RESULT.
- After 3 commits, assert reset for one cycle during ARMED -> all tallies 0, ballot_ready 0, next ballot counts from 0.
